// File: rtl/spi_frame_router.sv
// spi_frame_router: parses 16-bit service-protocol words from the SPI receiver.
// It buffers the payload of each frame addressed to one of CHANNELS consecutive
// addresses and checks the frame checksum. Only a frame with a good checksum is
// released to its channel as a valid/ready beat stream.
//
// state | meaning
// IDLE  | hunting for an address word {addr,8'h00} within the channel range
// HDR   | expecting {size,cmd}
// DATA  | collecting payload words into the buffer
// CSUM  | expecting the checksum word
// PNUM  | expecting the packet-number word (value ignored)
// SKIP  | discarding the remaining words of a rejected frame
// DRAIN | presenting buffered payload to the addressed channel
module spi_frame_router #(
  parameter int         CHANNELS     = 4,
  parameter logic [7:0] BASE_ADDR    = 8'hAB,
  parameter int         MAX_WORDS    = 64,
  parameter int         WORD_TIMEOUT = 1024,
  localparam int        CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic [15:0]   in_data,
  input  logic          in_request,
  output logic          in_busy,
  output logic [15:0]   out_data,
  output logic [CW-1:0] out_chan,
  output logic [7:0]    out_cmd,
  output logic          out_last,
  output logic          out_nodata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          frame_ok,
  output logic          err_csum,
  output logic          err_size,
  output logic          err_timeout,
  output logic          err_drop,
  output logic [15:0]   good_cnt
);

  localparam int AW = $clog2(MAX_WORDS);
  localparam int TW = $clog2(WORD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_CSUM, S_PNUM, S_SKIP, S_DRAIN
  } state_t;

  state_t        state;
  logic [CW-1:0] chan_q;
  logic [7:0]    size_q;
  logic [7:0]    cmd_q;
  logic [15:0]   sum_q;
  logic [8:0]    wr_cnt;
  logic [8:0]    rd_cnt;
  logic [8:0]    skip_cnt;
  logic [TW-1:0] timer;
  logic [15:0]   mem [MAX_WORDS];

  logic [8:0]    addr_off;
  logic          addr_hit;
  logic          timing_active;
  logic          expire;
  logic          buf_wr;
  logic          hs;
  logic [15:0]   sum_add;

  // Address decode, word timer expiry and handshake qualifiers.
  always_comb begin
    addr_off      = {1'b0, in_data[15:8]} - {1'b0, BASE_ADDR};
    addr_hit      = (in_data[7:0] == 8'h00) && (in_data != 16'h0000) &&
                    (in_data[15:8] >= BASE_ADDR) && (addr_off < 9'(CHANNELS));
    timing_active = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM) ||
                    (state == S_PNUM) || (state == S_SKIP);
    expire        = timing_active && (timer == TW'(WORD_TIMEOUT - 1));
    buf_wr        = nRst && in_request && !expire && (state == S_DATA);
    hs            = out_valid && out_ready;
    sum_add       = sum_q + in_data;
  end

  // Payload buffer; contents need no reset because pointers gate every read.
  always_ff @(posedge clk) begin
    if (buf_wr) mem[wr_cnt[AW-1:0]] <= in_data;
  end

  // Frame parser, drain sequencer and status pulses.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state       <= S_IDLE;
      chan_q      <= '0;
      size_q      <= '0;
      cmd_q       <= '0;
      sum_q       <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      skip_cnt    <= '0;
      timer       <= '0;
      in_busy     <= 1'b0;
      out_data    <= '0;
      out_chan    <= '0;
      out_cmd     <= '0;
      out_last    <= 1'b0;
      out_nodata  <= 1'b0;
      out_valid   <= 1'b0;
      frame_ok    <= 1'b0;
      err_csum    <= 1'b0;
      err_size    <= 1'b0;
      err_timeout <= 1'b0;
      err_drop    <= 1'b0;
      good_cnt    <= '0;
    end else begin
      frame_ok    <= 1'b0;
      err_csum    <= 1'b0;
      err_size    <= 1'b0;
      err_timeout <= 1'b0;
      err_drop    <= 1'b0;
      if (expire) begin
        // A word arriving on the expiry cycle is discarded with the frame.
        err_timeout <= 1'b1;
        state       <= S_IDLE;
        wr_cnt      <= '0;
        timer       <= '0;
      end else begin
        if (in_request) timer <= '0;
        else if (timing_active) timer <= timer + TW'(1);
        case (state)
          S_IDLE: begin
            if (in_request && addr_hit) begin
              chan_q <= addr_off[CW-1:0];
              sum_q  <= in_data;
              state  <= S_HDR;
            end
          end
          S_HDR: begin
            if (in_request) begin
              size_q <= in_data[15:8];
              cmd_q  <= in_data[7:0];
              sum_q  <= sum_add;
              wr_cnt <= '0;
              if ({1'b0, in_data[15:8]} > 9'(MAX_WORDS)) begin
                // Payload, checksum and packet number are all skipped.
                err_size <= 1'b1;
                skip_cnt <= {1'b0, in_data[15:8]} + 9'd2;
                state    <= S_SKIP;
              end else if (in_data[15:8] == 8'h00) begin
                state <= S_CSUM;
              end else begin
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (in_request) begin
              sum_q  <= sum_add;
              wr_cnt <= wr_cnt + 9'd1;
              if (wr_cnt + 9'd1 == {1'b0, size_q}) state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (in_request) begin
              if (in_data == sum_q) begin
                state <= S_PNUM;
              end else begin
                err_csum <= 1'b1;
                skip_cnt <= 9'd1;
                state    <= S_SKIP;
              end
            end
          end
          S_PNUM: begin
            if (in_request) begin
              frame_ok  <= 1'b1;
              good_cnt  <= good_cnt + 16'd1;
              state     <= S_DRAIN;
              in_busy   <= 1'b1;
              out_valid <= 1'b1;
              out_chan  <= chan_q;
              out_cmd   <= cmd_q;
              rd_cnt    <= 9'd1;
              if (size_q == 8'h00) begin
                out_data   <= '0;
                out_nodata <= 1'b1;
                out_last   <= 1'b1;
              end else begin
                out_data   <= mem[0];
                out_nodata <= 1'b0;
                out_last   <= (size_q == 8'd1);
              end
            end
          end
          S_SKIP: begin
            if (in_request) begin
              skip_cnt <= skip_cnt - 9'd1;
              if (skip_cnt == 9'd1) begin
                state  <= S_IDLE;
                wr_cnt <= '0;
              end
            end
          end
          S_DRAIN: begin
            if (in_request) err_drop <= 1'b1;
            if (hs) begin
              if (out_last) begin
                out_valid  <= 1'b0;
                out_last   <= 1'b0;
                out_nodata <= 1'b0;
                out_data   <= '0;
                in_busy    <= 1'b0;
                wr_cnt     <= '0;
                rd_cnt     <= '0;
                state      <= S_IDLE;
              end else begin
                out_data <= mem[rd_cnt[AW-1:0]];
                out_last <= (rd_cnt + 9'd1 == {1'b0, size_q});
                rd_cnt   <= rd_cnt + 9'd1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
